// File: rtl/fluid_level_monitor.sv
// Tank level monitor: samples a thermometer-coded float-sensor bank on a prescaled tick,
// debounces level/error, and raises FULL/EMPTY/ERROR/HIGH/LOW interrupts via IER/IFR.
module fluid_level_monitor #(
  parameter int SENSORS  = 8,
  parameter int CLK_DIV  = 10000000,
  parameter int DEBOUNCE = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         wr_addr,
  input  logic               wr_en,
  input  logic [31:0]        wr_data,
  input  logic [3:0]         wr_strb,
  input  logic [3:0]         rd_addr,
  input  logic               rd_en,
  output logic [31:0]        rd_data,
  input  logic [SENSORS-1:0] sensor_in,
  output logic               irq
);

  localparam int LW = $clog2(SENSORS + 1);
  localparam int DW = $clog2(CLK_DIV);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam int EV_FULL  = 0;
  localparam int EV_EMPTY = 1;
  localparam int EV_ERROR = 2;
  localparam int EV_HIGH  = 3;
  localparam int EV_LOW   = 4;

  typedef enum logic [1:0] {REG_LVL, REG_IER, REG_IFR, REG_THR} reg_e;

  typedef struct packed {
    logic [LW-1:0] lvl;
    logic          err;
  } sample_t;

  logic [SENSORS-1:0] r_sync1, r_sync2;
  logic [DW-1:0]      r_div;
  sample_t            r_cand;
  logic [CW-1:0]      r_cnt;
  logic [LW-1:0]      r_lvl;
  logic               r_err;
  logic [4:0]         r_evt;
  logic [4:0]         r_ier;
  logic [4:0]         r_ifr;
  logic [LW-1:0]      r_low;
  logic [LW-1:0]      r_high;

  logic               w_tick;
  sample_t            w_raw;
  logic [SENSORS-1:0] w_mask;
  logic               w_same;
  logic [CW-1:0]      w_cnt_next;
  logic               w_commit;
  logic [4:0]         w_evt;
  logic               w_wr_ier, w_wr_ifr, w_wr_thr;
  logic [4:0]         w_clr;
  logic               w_unused;

  assign w_tick = (r_div == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_raw  = '0;
    w_mask = '0;
    for (int i = 0; i < SENSORS; i++) begin
      if (r_sync2[i]) w_raw.lvl = LW'(i + 1);
    end
    for (int i = 0; i < SENSORS; i++) begin
      w_mask[i] = (LW'(i) < w_raw.lvl);
    end
    w_raw.err = (r_sync2 != w_mask);
  end

  assign w_same     = (w_raw == r_cand);
  assign w_cnt_next = (r_cnt == CW'(DEBOUNCE - 1)) ? r_cnt : r_cnt + 1'b1;
  // With DEBOUNCE=1 every tick commits the raw sample, matching or not.
  assign w_commit   = w_tick && ((DEBOUNCE == 1) || (w_same && (w_cnt_next == CW'(DEBOUNCE - 1))));

  always_comb begin
    w_evt           = '0;
    w_evt[EV_FULL]  = (w_raw.lvl == LW'(SENSORS)) && (r_lvl != LW'(SENSORS));
    w_evt[EV_EMPTY] = (w_raw.lvl == '0) && (r_lvl != '0);
    w_evt[EV_ERROR] = w_raw.err && !r_err;
    w_evt[EV_HIGH]  = (r_lvl <= r_high) && (w_raw.lvl > r_high);
    w_evt[EV_LOW]   = (r_lvl >= r_low) && (w_raw.lvl < r_low);
  end

  assign w_wr_ier = wr_en && (wr_addr[3:2] == REG_IER);
  assign w_wr_ifr = wr_en && (wr_addr[3:2] == REG_IFR);
  assign w_wr_thr = wr_en && (wr_addr[3:2] == REG_THR);
  assign w_clr    = (w_wr_ifr && wr_strb[0]) ? wr_data[4:0] : '0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_div   <= DW'(CLK_DIV - 1);
      r_cand  <= '0;
      r_cnt   <= '0;
      r_lvl   <= '0;
      r_err   <= 1'b0;
      r_evt   <= '0;
      r_ier   <= '0;
      r_ifr   <= '0;
      r_low   <= '0;
      r_high  <= LW'(SENSORS);
    end else begin
      r_sync1 <= sensor_in;
      r_sync2 <= r_sync1;
      r_div   <= w_tick ? DW'(CLK_DIV - 1) : r_div - 1'b1;

      if (w_tick) begin
        if (!w_same) begin
          r_cand <= w_raw;
          r_cnt  <= '0;
        end else begin
          r_cnt  <= w_cnt_next;
        end
      end

      if (w_commit) begin
        r_lvl <= w_raw.lvl;
        r_err <= w_raw.err;
      end
      r_evt <= w_commit ? w_evt : '0;

      // A flag being raised wins over a W1C clear landing on the same clock.
      r_ifr <= (r_ifr & ~w_clr) | r_evt;

      if (w_wr_ier && wr_strb[0]) r_ier  <= wr_data[4:0];
      if (w_wr_thr && wr_strb[0]) r_low  <= wr_data[LW-1:0];
      if (w_wr_thr && wr_strb[1]) r_high <= wr_data[LW+7:8];
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (reg_e'(rd_addr[3:2]))
        REG_LVL: begin
          rd_data[LW-1:0] = r_lvl;
          rd_data[31]     = r_err;
        end
        REG_IER: rd_data[4:0] = r_ier;
        REG_IFR: rd_data[4:0] = r_ifr;
        REG_THR: begin
          rd_data[LW-1:0]  = r_low;
          rd_data[LW+7:8]  = r_high;
        end
        default: rd_data = '0;
      endcase
    end
  end

  assign irq = |(r_ifr & r_ier);

  assign w_unused = ^{wr_addr[1:0], rd_addr[1:0], wr_data, wr_strb[3:2]};

endmodule
